// File: rtl/vga_pkg.sv
// Shared types, timing constants and helpers for the VGA image window renderer.
package vga_pkg;

  // Compositing modes; RSVD renders like SINGLE.
  typedef enum logic [1:0] {
    SINGLE = 2'd0,
    SPLIT  = 2'd1,
    DIFF   = 2'd2,
    RSVD   = 2'd3
  } mode_e;

  // Visible area of the 640x480 timing the counters run in.
  localparam int H_VISIBLE = 640;
  localparam int V_VISIBLE = 480;

  // Expand a pix_w-bit gray value (held in the low bits of pix) to 8 bits:
  // left-justify and fill the low bits by repeating the value from its MSB.
  function automatic logic [7:0] gray_expand(input logic [7:0] pix, input int pix_w);
    logic [7:0] res;
    int         src;
    res = 8'h00;
    for (int i = 0; i < 8; i++) begin
      src = pix_w - 1 - (i % pix_w);
      res[7 - i] = pix[src[2:0]];
    end
    return res;
  endfunction

endpackage

// File: rtl/vga_flag_delay.sv
// Fixed-depth shift register carrying per-pixel flags alongside the memory read.
module vga_flag_delay #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 2
) (
  input  logic             clk_25,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift the flags one stage per pixel clock.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i - 1];
      end
    end
  end

  assign q_o = stage_q[DEPTH - 1];

endmodule

// File: rtl/vga_image_window.sv
// Grayscale image window: shared frame-buffer address generation, latency-matched
// flag pipeline and compositing of up to four sources into r/g/b.
module vga_image_window
  import vga_pkg::*;
#(
  parameter int IMG_WIDTH  = 400,
  parameter int IMG_HEIGHT = 400,
  parameter int H_START    = 120,
  parameter int V_START    = 40,
  parameter int SCALE_LOG2 = 0,
  parameter int PIX_W      = 8,
  parameter int ADDR_W     = 19,
  parameter int NUM_SRC    = 2,
  parameter int MEM_LAT    = 1
) (
  input  logic                     clk_25,
  input  logic                     rst_n,
  input  logic [9:0]               hs,
  input  logic [9:0]               vs,
  input  logic [1:0]               mode,
  input  logic [1:0]               src_sel,
  input  logic [NUM_SRC*PIX_W-1:0] pixel_data,
  output logic [ADDR_W-1:0]        pixel_address,
  output logic [7:0]               r,
  output logic [7:0]               g,
  output logic [7:0]               b,
  output logic                     in_window,
  output logic                     frame_start
);

  localparam int WIN_W     = IMG_WIDTH << SCALE_LOG2;
  localparam int WIN_H     = IMG_HEIGHT << SCALE_LOG2;
  localparam int SPLIT_COL = H_START + ((IMG_WIDTH / 2) << SCALE_LOG2);
  localparam int CW        = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;
  localparam int PAD_W     = 4 * PIX_W;
  localparam logic [CW-1:0] SUB_MAX = CW'((1 << SCALE_LOG2) - 1);

  // Frame configuration
  mode_e       mode_q;
  logic [1:0]  src_sel_q;
  logic        armed_q;
  logic        frame_start_q;
  logic        cfg_latch_s;

  // Address generation
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [CW-1:0]     hsub_q, hsub_d;
  logic [CW-1:0]     vsub_q, vsub_d;
  logic              in_win_s, origin_s, last_col_s, right_s;

  // Output stage
  logic [1:0]       dly_flags_s;
  logic [PAD_W-1:0] data_pad_s;
  logic [PIX_W-1:0] src0_s, src1_s, diff_s, single_s, pix_s;
  logic [7:0]       gray_q;
  logic             in_window_q;

  assign cfg_latch_s = (hs == 10'd0) && (vs == 10'd0);

  // Latch mode/source at frame start so a frame is never rendered with mixed settings.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      mode_q        <= SINGLE;
      src_sel_q     <= 2'd0;
      armed_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (cfg_latch_s) begin
      mode_q        <= mode_e'(mode);
      src_sel_q     <= src_sel;
      armed_q       <= 1'b1;
      frame_start_q <= 1'b1;
    end else begin
      frame_start_q <= 1'b0;
    end
  end

  // Classify the current counter position against the window and its split line.
  always_comb begin
    in_win_s   = armed_q &&
                 (int'(hs) >= H_START) && (int'(hs) < H_START + WIN_W) &&
                 (int'(vs) >= V_START) && (int'(vs) < V_START + WIN_H);
    origin_s   = (int'(hs) == H_START) && (int'(vs) == V_START);
    last_col_s = (int'(hs) == H_START + WIN_W - 1);
    right_s    = in_win_s && (int'(hs) >= SPLIT_COL);
  end

  // Incremental address walk: hsub/vsub count pixel and row repeats when upscaling.
  always_comb begin
    logic [ADDR_W-1:0] eff_addr, eff_row;
    logic [CW-1:0]     eff_hsub, eff_vsub;
    eff_addr = origin_s ? '0 : cur_q;
    eff_row  = origin_s ? '0 : row_q;
    eff_hsub = origin_s ? '0 : hsub_q;
    eff_vsub = origin_s ? '0 : vsub_q;
    addr_d   = '0;
    cur_d    = cur_q;
    row_d    = row_q;
    hsub_d   = hsub_q;
    vsub_d   = vsub_q;
    if (in_win_s) begin
      addr_d = eff_addr;
      if (last_col_s) begin
        hsub_d = '0;
        if (eff_vsub == SUB_MAX) begin
          vsub_d = '0;
          row_d  = eff_row + ADDR_W'(IMG_WIDTH);
          cur_d  = eff_row + ADDR_W'(IMG_WIDTH);
        end else begin
          vsub_d = eff_vsub + CW'(1);
          row_d  = eff_row;
          cur_d  = eff_row;
        end
      end else begin
        row_d  = eff_row;
        vsub_d = eff_vsub;
        if (eff_hsub == SUB_MAX) begin
          hsub_d = '0;
          cur_d  = eff_addr + ADDR_W'(1);
        end else begin
          hsub_d = eff_hsub + CW'(1);
          cur_d  = eff_addr;
        end
      end
    end else begin
      addr_d = '0;
    end
  end

  // Register the read address and the walk state.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      cur_q  <= '0;
      row_q  <= '0;
      hsub_q <= '0;
      vsub_q <= '0;
    end else begin
      addr_q <= addr_d;
      cur_q  <= cur_d;
      row_q  <= row_d;
      hsub_q <= hsub_d;
      vsub_q <= vsub_d;
    end
  end

  // Window and split flags arrive at the output stage together with the memory data.
  vga_flag_delay #(
    .DEPTH (MEM_LAT + 1),
    .WIDTH (2)
  ) u_flag_delay (
    .clk_25 (clk_25),
    .rst_n  (rst_n),
    .d_i    ({right_s, in_win_s}),
    .q_o    (dly_flags_s)
  );

  // Pick or combine the returned source pixels according to the frame's mode.
  always_comb begin
    data_pad_s = PAD_W'(pixel_data);
    src0_s     = data_pad_s[0 +: PIX_W];
    src1_s     = data_pad_s[PIX_W +: PIX_W];
    diff_s     = (src0_s >= src1_s) ? (src0_s - src1_s) : (src1_s - src0_s);
    single_s   = src0_s;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (src_sel_q == 2'(k)) begin
        single_s = data_pad_s[k*PIX_W +: PIX_W];
      end
    end
    case (mode_q)
      SPLIT:   pix_s = (NUM_SRC > 1 && dly_flags_s[1]) ? src1_s : src0_s;
      DIFF:    pix_s = (NUM_SRC > 1) ? diff_s : src0_s;
      default: pix_s = single_s;
    endcase
  end

  // Output register: gray level inside the window, black elsewhere.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      gray_q      <= 8'h00;
      in_window_q <= 1'b0;
    end else if (dly_flags_s[0]) begin
      gray_q      <= gray_expand(8'(pix_s), PIX_W);
      in_window_q <= 1'b1;
    end else begin
      gray_q      <= 8'h00;
      in_window_q <= 1'b0;
    end
  end

  assign pixel_address = addr_q;
  assign r             = gray_q;
  assign g             = gray_q;
  assign b             = gray_q;
  assign in_window     = in_window_q;
  assign frame_start   = frame_start_q;

endmodule

// File: doc/vga_image_window.md
# vga_image_window

Parametrised grayscale image window renderer for the 640x480 VGA path, driven by the 25 MHz pixel clock and the horizontal and vertical pixel counters. It generates one shared frame-buffer read address for up to `NUM_SRC` image memories (ROM/RAM), compensates for their read latency, and composites the returned pixels into `r`, `g` and `b`. Compositing modes are single source, split view or absolute difference, with integer power-of-two upscaling. Mode changes take effect only at frame start, so no frame is ever torn.

## Interface
- `IMG_WIDTH`, default 400: source image width in pixels.
- `IMG_HEIGHT`, default 400: source image height in pixels.
- `H_START`, default 120: first on-screen window column.
- `V_START`, default 40: first on-screen window row.
- `SCALE_LOG2`, default 0: upscale factor 2^SCALE_LOG2; window is (IMG_WIDTH<<S) x (IMG_HEIGHT<<S).
- `PIX_W`, default 8: source pixel width, 1..8.
- `ADDR_W`, default 19: address width; must satisfy 2^ADDR_W >= IMG_WIDTH*IMG_HEIGHT.
- `NUM_SRC`, default 2: number of source memories, 1..4.
- `MEM_LAT`, default 1: memory read latency in cycles, address to data, 0..3.
- `clk_25  input  1`: pixel clock.
- `rst_n  input  1`: reset, asynchronous, active-low.
- `hs  input  10`: horizontal pixel counter.
- `vs  input  10`: vertical pixel counter.
- `mode  input  2`: 0 SINGLE, 1 SPLIT, 2 DIFF, 3 reserved (behaves as SINGLE).
- `src_sel  input  2`: source index for SINGLE mode.
- `pixel_data  input  NUM_SRC*PIX_W`: source k occupies bits [k*PIX_W +: PIX_W].
- `pixel_address  output  ADDR_W`: shared read address.
- `r`, `g`, `b`  output  8 each: gray level, r = g = b.
- `in_window  output  1`: asserted when `r`/`g`/`b` carry image data.
- `frame_start  output  1`: one-cycle pulse when configuration is latched.

## Operation
- Configuration latch: when hs==0 && vs==0, register `mode` and `src_sel`, pulse `frame_start`, set `armed`=1. Configuration is stable for the rest of the frame.
- `armed` is cleared by reset. While `armed`=0, no address is generated and the output is black. A reset mid-frame therefore blanks the screen until the next frame start.
- Window: hs in [H_START, H_START+(IMG_WIDTH<<S)) and vs in [V_START, V_START+(IMG_HEIGHT<<S)).
- Address generation is incremental; no multiplier is used.
  - At (H_START, V_START): addr = 0, row_base = 0, hsub = 0, vsub = 0.
  - Each in-window cycle: hsub++. When hsub wraps at 2^S, addr++.
  - On the last window column: vsub++. If vsub wraps, row_base += IMG_WIDTH and the next row starts at the new row_base. Otherwise the next row restarts at the old row_base (row repeat).
- Source select per pixel:
  - SINGLE: source `src_sel`. If src_sel >= NUM_SRC, use source 0.
  - SPLIT: image column < IMG_WIDTH/2 uses source 0, otherwise source 1. The split flag is delayed through the pipeline alongside the window flag.
  - DIFF: |src0 - src1|, computed at PIX_W bits, unsigned, no overflow possible.
  - If NUM_SRC==1, SPLIT and DIFF degrade to SINGLE using source 0.
- Gray expansion to 8 bits: left-justify, then fill the low bits by repeating the MSBs. Examples: PIX_W=4, 0xA -> 0xAA; PIX_W=1, 1 -> 0xFF.
- Outside the window or while unarmed: `r` = `g` = `b` = 0, `pixel_address` = 0, `in_window` = 0.

## Timing
- Cycle n: hs/vs presented.
- Cycle n+1: `pixel_address` registered.
- Cycle n+1+MEM_LAT: memory data valid.
- Cycle n+2+MEM_LAT: `r`/`g`/`b` and `in_window` registered.
- Total latency LAT = MEM_LAT + 2. The window and split flags go through a shift register of depth MEM_LAT+1 ending at the output register.
- `frame_start` is asserted in cycle n+1 for hs==vs==0 in cycle n. The latched configuration applies from cycle n+1.
- Reset values (asynchronous): `pixel_address` = 0, `r`/`g`/`b` = 0, `in_window` = 0, `frame_start` = 0, mode = SINGLE, src_sel = 0, armed = 0, all counters and delay stages = 0.
- A mode change mid-frame has no visible effect until after the next frame_start.

## Structure
- Package `vga_pkg`:
  - `mode_e` enum (SINGLE, SPLIT, DIFF, RSVD).
  - 640x480 timing constants: H_VISIBLE, V_VISIBLE.
  - Function `gray_expand(PIX_W)`.
- Sub-module `vga_flag_delay`: parametrised-depth shift register for the window and split flags, asynchronous active-low reset.

## Test plan
- Reset, then one frame with IMG 4x3, H_START=2, V_START=1, MEM_LAT=1, S=0, SINGLE src 0 -> addresses 0..3 at hs=2..5 of vs=1 (one cycle later), 4..7 on vs=2; `in_window` rises at hs=2+3 cycles; outside the window, address 0 and black.
- S=1, IMG 2x2 -> address sequence per row 0,0,1,1, rows repeated: 0,0,1,1 / 0,0,1,1 / 2,2,3,3 / 2,2,3,3.
- SPLIT with src0=0x10, src1=0xF0, IMG_WIDTH=4 -> output 0x10 for image columns 0-1 and 0xF0 for columns 2-3, with no column offset error for MEM_LAT = 0, 1, 3.
- DIFF with src0=0x20, src1=0x80 -> 0x60. Swapping the operands also gives 0x60. PIX_W=4 with src0=0x2, src1=0xB -> 0x99.
- Change mode from SINGLE to DIFF mid-frame -> the rest of the frame stays SINGLE; DIFF starts after `frame_start`. src_sel=3 with NUM_SRC=2 -> source 0.
- Assert `rst_n` low mid-window -> outputs are 0 immediately (asynchronously); after release, black until the next hs==vs==0, then a correct frame from address 0.
